// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared encodings for the OTTER control unit and decoder
package otter_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_OPIMM  = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_INTR
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_LUI  = 4'b1001;

    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_UIMM = 2'd1;
    localparam logic [1:0] SRCA_NRS1 = 2'd2;

    localparam logic [2:0] SRCB_RS2  = 3'd0;
    localparam logic [2:0] SRCB_IIMM = 3'd1;
    localparam logic [2:0] SRCB_SIMM = 3'd2;
    localparam logic [2:0] SRCB_PC   = 3'd3;
    localparam logic [2:0] SRCB_CSR  = 3'd4;

    localparam logic [2:0] PC_NEXT   = 3'd0;
    localparam logic [2:0] PC_JALR   = 3'd1;
    localparam logic [2:0] PC_BRANCH = 3'd2;
    localparam logic [2:0] PC_JAL    = 3'd3;
    localparam logic [2:0] PC_MTVEC  = 3'd4;
    localparam logic [2:0] PC_MEPC   = 3'd5;

    localparam logic [1:0] RF_PC4 = 2'd0;
    localparam logic [1:0] RF_CSR = 2'd1;
    localparam logic [1:0] RF_MEM = 2'd2;
    localparam logic [1:0] RF_ALU = 2'd3;

    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;
    localparam logic [2:0] F3_SR    = 3'b101;

    // Reserved branch func3 values (010, 011) resolve to not-taken.
    function automatic logic branch_taken(input logic [2:0] func3, input logic eq,
                                          input logic lt, input logic ltu);
        case (func3)
            3'b000:  return eq;
            3'b001:  return !eq;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/otter_cu_dcdr.sv
// rtl/otter_cu_dcdr.sv - combinational instruction decode to ALU op and datapath selects
module otter_cu_dcdr import otter_pkg::*; (
    input  logic [31:0] ir,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  logic        int_taken,
    output logic [3:0]  alu_fun,
    output logic [1:0]  alu_srca,
    output logic [2:0]  alu_srcb,
    output logic [2:0]  pc_source,
    output logic [1:0]  rf_wr_sel
);

    opcode_t    opcode;
    logic [2:0] func3;

    assign opcode = opcode_t'(ir[6:0]);
    assign func3  = ir[14:12];

    always_comb begin
        alu_fun   = ALU_ADD;
        alu_srca  = SRCA_RS1;
        alu_srcb  = SRCB_RS2;
        pc_source = PC_NEXT;
        rf_wr_sel = RF_PC4;
        case (opcode)
            OPC_LOAD: begin
                alu_srcb  = SRCB_IIMM;
                rf_wr_sel = RF_MEM;
            end
            OPC_STORE: alu_srcb = SRCB_SIMM;
            OPC_OP: begin
                alu_fun   = {ir[30], func3};
                rf_wr_sel = RF_ALU;
            end
            OPC_OPIMM: begin
                // ir[30] is immediate data except on shifts, where it picks srai over srli
                alu_fun   = (func3 == F3_SR) ? {ir[30], func3} : {1'b0, func3};
                alu_srcb  = SRCB_IIMM;
                rf_wr_sel = RF_ALU;
            end
            OPC_LUI: begin
                alu_fun   = ALU_LUI;
                alu_srca  = SRCA_UIMM;
                rf_wr_sel = RF_ALU;
            end
            OPC_AUIPC: begin
                alu_srca  = SRCA_UIMM;
                alu_srcb  = SRCB_PC;
                rf_wr_sel = RF_ALU;
            end
            OPC_JAL:  pc_source = PC_JAL;
            OPC_JALR: pc_source = PC_JALR;
            OPC_BRANCH: begin
                if (branch_taken(func3, br_eq, br_lt, br_ltu))
                    pc_source = PC_BRANCH;
            end
            OPC_SYSTEM: begin
                case (func3)
                    F3_CSRRW: begin
                        alu_fun   = ALU_LUI;
                        rf_wr_sel = RF_CSR;
                    end
                    F3_CSRRS: begin
                        alu_fun   = ALU_OR;
                        alu_srcb  = SRCB_CSR;
                        rf_wr_sel = RF_CSR;
                    end
                    F3_CSRRC: begin
                        alu_fun   = ALU_AND;
                        alu_srca  = SRCA_NRS1;
                        alu_srcb  = SRCB_CSR;
                        rf_wr_sel = RF_CSR;
                    end
                    F3_MRET: pc_source = PC_MEPC;
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (int_taken)
            pc_source = PC_MTVEC;
    end

endmodule

// File: rtl/otter_control_unit.sv
// rtl/otter_control_unit.sv - multi-cycle OTTER control FSM with enables and decoder instance
module otter_control_unit import otter_pkg::*; (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] ir,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  logic        intr,
    input  logic        csr_mie,
    output logic        pc_rst,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_rden1,
    output logic        mem_rden2,
    output logic        mem_we2,
    output logic        csr_we,
    output logic        int_taken,
    output logic        mret_exec,
    output logic [3:0]  alu_fun,
    output logic [1:0]  alu_srca,
    output logic [2:0]  alu_srcb,
    output logic [2:0]  pc_source,
    output logic [1:0]  rf_wr_sel
);

    state_t     state;
    state_t     next_state;
    opcode_t    opcode;
    logic [2:0] func3;
    logic       trap_pending;
    logic [3:0] d_alu_fun;
    logic [1:0] d_alu_srca;
    logic [2:0] d_alu_srcb;
    logic [2:0] d_pc_source;
    logic [1:0] d_rf_wr_sel;

    assign opcode       = opcode_t'(ir[6:0]);
    assign func3        = ir[14:12];
    assign trap_pending = intr & csr_mie;

    otter_cu_dcdr u_dcdr (
        .ir        (ir),
        .br_eq     (br_eq),
        .br_lt     (br_lt),
        .br_ltu    (br_ltu),
        .int_taken (int_taken),
        .alu_fun   (d_alu_fun),
        .alu_srca  (d_alu_srca),
        .alu_srcb  (d_alu_srcb),
        .pc_source (d_pc_source),
        .rf_wr_sel (d_rf_wr_sel)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= ST_INIT;
        else
            state <= next_state;
    end

    // Interrupts are only taken at an instruction boundary (end of EXEC or WB).
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:  next_state = ST_FETCH;
            ST_FETCH: next_state = ST_EXEC;
            ST_EXEC: begin
                if (opcode == OPC_LOAD)
                    next_state = ST_WB;
                else
                    next_state = trap_pending ? ST_INTR : ST_FETCH;
            end
            ST_WB:    next_state = trap_pending ? ST_INTR : ST_FETCH;
            ST_INTR:  next_state = ST_FETCH;
            default:  next_state = ST_INIT;
        endcase
    end

    always_comb begin
        pc_rst    = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        case (state)
            ST_INIT:  pc_rst = 1'b1;
            ST_FETCH: mem_rden1 = 1'b1;
            ST_EXEC: begin
                pc_write = (opcode != OPC_LOAD);
                case (opcode)
                    OPC_LOAD:  mem_rden2 = 1'b1;
                    OPC_STORE: mem_we2 = 1'b1;
                    OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                        reg_write = 1'b1;
                    OPC_SYSTEM: begin
                        case (func3)
                            F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
                                csr_we    = 1'b1;
                                reg_write = 1'b1;
                            end
                            F3_MRET: mret_exec = 1'b1;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    // Selects are parked at zero while the PC is being reset.
    always_comb begin
        alu_fun   = d_alu_fun;
        alu_srca  = d_alu_srca;
        alu_srcb  = d_alu_srcb;
        pc_source = d_pc_source;
        rf_wr_sel = d_rf_wr_sel;
        if (state == ST_INIT) begin
            alu_fun   = ALU_ADD;
            alu_srca  = SRCA_RS1;
            alu_srcb  = SRCB_RS2;
            pc_source = PC_NEXT;
            rf_wr_sel = RF_PC4;
        end
    end

endmodule

// File: tb/tb_otter_control_unit.sv
// tb/tb_otter_control_unit.sv - self-checking bench for otter_control_unit
module tb_otter_control_unit;

    localparam int P_INIT  = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC  = 2;
    localparam int P_WB    = 3;
    localparam int P_INTR  = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0;
    logic        intr = 1'b0, csr_mie = 1'b0;
    logic        pc_rst, pc_write, reg_write, mem_rden1, mem_rden2, mem_we2;
    logic        csr_we, int_taken, mret_exec;
    logic [3:0]  alu_fun;
    logic [1:0]  alu_srca, rf_wr_sel;
    logic [2:0]  alu_srcb, pc_source;

    int tests = 0;
    int fails = 0;
    int ph = P_INIT;

    always #5 CLK = ~CLK;

    otter_control_unit dut (
        .CLK(CLK), .RST_N(RST_N), .ir(ir),
        .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
        .intr(intr), .csr_mie(csr_mie),
        .pc_rst(pc_rst), .pc_write(pc_write), .reg_write(reg_write),
        .mem_rden1(mem_rden1), .mem_rden2(mem_rden2), .mem_we2(mem_we2),
        .csr_we(csr_we), .int_taken(int_taken), .mret_exec(mret_exec),
        .alu_fun(alu_fun), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .pc_source(pc_source), .rf_wr_sel(rf_wr_sel)
    );

    wire [22:0] obs = {pc_rst, pc_write, reg_write, mem_rden1, mem_rden2, mem_we2,
                       csr_we, int_taken, mret_exec, alu_fun, alu_srca, alu_srcb,
                       pc_source, rf_wr_sel};

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Expected outputs per phase, straight from the instruction-level rules.
    function automatic logic [22:0] model(input int p, input logic [31:0] i,
                                          input logic eq, input logic lt, input logic ltu);
        logic pcr = 0, pcw = 0, rw = 0, r1 = 0, r2 = 0, we = 0, cw = 0, it = 0, mx = 0;
        int   af = 0, sa = 0, sb = 0, ps = 0, rs = 0;
        int   f3 = int'(i[14:12]);
        logic tk;
        case (p)
            P_INIT:  pcr = 1;
            P_FETCH: r1 = 1;
            P_INTR:  begin it = 1; pcw = 1; ps = 4; end
            P_WB:    begin rw = 1; pcw = 1; sb = 1; rs = 2; end
            default: begin
                pcw = 1;
                case (i[6:0])
                    7'b0000011: begin pcw = 0; r2 = 1; sb = 1; rs = 2; end
                    7'b0100011: begin we = 1; sb = 2; end
                    7'b0110011: begin rw = 1; rs = 3; af = (i[30] ? 8 : 0) + f3; end
                    7'b0010011: begin rw = 1; rs = 3; sb = 1;
                                      af = ((f3 == 5 && i[30]) ? 8 : 0) + f3; end
                    7'b0110111: begin rw = 1; rs = 3; af = 9; sa = 1; end
                    7'b0010111: begin rw = 1; rs = 3; sa = 1; sb = 3; end
                    7'b1101111: begin rw = 1; ps = 3; end
                    7'b1100111: begin rw = 1; ps = 1; end
                    7'b1100011: begin
                        case (f3)
                            0: tk = eq;   1: tk = !eq;
                            4: tk = lt;   5: tk = !lt;
                            6: tk = ltu;  7: tk = !ltu;
                            default: tk = 0;
                        endcase
                        ps = tk ? 2 : 0;
                    end
                    7'b1110011: begin
                        if (f3 == 0) begin mx = 1; ps = 5; end
                        else if (f3 >= 1 && f3 <= 3) begin
                            cw = 1; rw = 1; rs = 1;
                            if (f3 == 1) af = 9;
                            if (f3 == 2) begin af = 6; sb = 4; end
                            if (f3 == 3) begin af = 7; sa = 2; sb = 4; end
                        end
                    end
                    default: ;
                endcase
            end
        endcase
        return {pcr, pcw, rw, r1, r2, we, cw, it, mx, 4'(af), 2'(sa), 3'(sb), 3'(ps), 2'(rs)};
    endfunction

    function automatic logic [22:0] mask(input int p);
        if (p == P_FETCH) return 23'h7FC000;
        if (p == P_INTR)  return 23'h7FC01C;
        return 23'h7FFFFF;
    endfunction

    function automatic int nxt(input int p, input logic [31:0] i, input logic irq, input logic mie);
        case (p)
            P_INIT:  return P_FETCH;
            P_FETCH: return P_EXEC;
            P_EXEC:  return (i[6:0] == 7'b0000011) ? P_WB : ((irq && mie) ? P_INTR : P_FETCH);
            P_WB:    return (irq && mie) ? P_INTR : P_FETCH;
            default: return P_FETCH;
        endcase
    endfunction

    task automatic chk(input string tag);
        logic [22:0] e;
        logic [22:0] m;
        e = model(ph, ir, br_eq, br_lt, br_ltu);
        m = mask(ph);
        tests++;
        assert ((obs & m) === (e & m)) else begin
            fails++;
            $error("FAIL %s phase=%0d ir=%h observed=%h expected=%h", tag, ph, ir, obs & m, e & m);
        end
    endtask

    task automatic tick();
        ph = nxt(ph, ir, intr, csr_mie);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] instr, input logic eq, input logic lt,
                             input logic ltu, input logic irq, input logic mie, input string tag);
        intr = rb(); csr_mie = rb();
        #1; chk({tag, "_fetch"});
        tick();
        ir = instr; br_eq = eq; br_lt = lt; br_ltu = ltu;
        if (instr[6:0] == 7'b0000011) begin intr = rb(); csr_mie = rb(); end
        else begin intr = irq; csr_mie = mie; end
        #1; chk(tag);
        if (ph == P_EXEC && instr[6:0] == 7'b0000011) begin
            tick();
            intr = irq; csr_mie = mie;
            #1; chk({tag, "_wb"});
        end
        tick();
        if (ph == P_INTR) begin
            #1; chk({tag, "_intr"});
            intr = 1'b0;
            tick();
        end
    endtask

    logic [6:0] ops [11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                             7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b1110011,
                             7'b1111111};

    initial begin
        repeat (2) @(posedge CLK);
        #1; chk("reset");
        RST_N = 1'b1;
        tick();

        run_instr(32'h00208033, 0, 0, 0, 0, 0, "add");
        run_instr(32'h40208033, 0, 0, 0, 0, 0, "sub");
        run_instr(32'h4020D093, 0, 0, 0, 0, 0, "srai");
        run_instr(32'h0000A083, 0, 0, 0, 0, 0, "lw");
        run_instr(32'h0000A083, 0, 0, 0, 1, 1, "lw_irq");
        run_instr(32'h00208463, 1, 0, 0, 0, 0, "beq_t");
        run_instr(32'h00208463, 0, 0, 0, 0, 0, "beq_nt");
        run_instr(32'h0020F463, 0, 0, 1, 0, 0, "bgeu_nt");
        run_instr(32'h0020F463, 0, 0, 0, 0, 0, "bgeu_t");
        run_instr(32'h00208033, 0, 0, 0, 1, 1, "add_irq");
        run_instr(32'h00208033, 0, 0, 0, 1, 0, "add_irq_masked");
        run_instr(32'h30200073, 0, 0, 0, 0, 0, "mret");
        run_instr(32'h30200073, 0, 0, 0, 1, 1, "mret_irq");
        run_instr(32'h34029073, 0, 0, 0, 0, 0, "csrrw");

        intr = 1'b0; csr_mie = 1'b0;
        #1; chk("prerst_fetch");
        tick();
        ir = 32'h00208033;
        #1; chk("prerst_exec");
        RST_N = 1'b0;
        ph = P_INIT;
        #1; chk("rst_async");
        @(posedge CLK);
        #1; chk("rst_hold");
        RST_N = 1'b1;
        tick();

        for (int n = 0; n < 300; n++) begin
            logic [31:0] r;
            r = $urandom;
            run_instr({r[31:7], ops[$urandom_range(0, 10)]}, rb(), rb(), rb(),
                      ($urandom_range(0, 2) == 0), rb(), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
